// File: rtl/snn_spike_rx_pkg.sv
// Shared types for the CNN->SNN spike receiver: data widths, buffered spike word, FSM states.
package snn_spike_pkg;

   localparam int TIME_W = 32;
   localparam int ADDR_W = 9;

   // "time" is a reserved word, hence the spk_ prefix on the fields.
   typedef struct packed {
      logic signed [TIME_W-1:0] spk_time;
      logic [ADDR_W-1:0]        spk_addr;
   } spike_t;

   localparam int SPIKE_W = $bits(spike_t);

   typedef enum logic {
      RX_IDLE,
      RX_WAIT_LOW
   } rx_state_e;

endpackage

// File: rtl/snn_spike_rx_if.sv
// Bundle of the CNN handshake, SNN spike stream and counter signals of snn_spike_rx.
interface snn_spike_rx_if
   import snn_spike_pkg::*;
#(
   parameter int CNT_W = 16
) ();

   logic                     i_cnn_spike_valid;
   logic                     o_cnn_spike_ack;
   logic signed [TIME_W-1:0] i_cnn_spike_time;
   logic [ADDR_W-1:0]        i_cnn_spike_addr;
   logic                     i_cnn_done;
   logic                     o_spk_valid;
   logic                     i_spk_ready;
   logic signed [TIME_W-1:0] o_spk_time;
   logic [ADDR_W-1:0]        o_spk_addr;
   logic                     o_stream_done;
   logic                     i_clear;
   logic [CNT_W-1:0]         o_spike_count;

   modport slave (
      input  i_cnn_spike_valid, i_cnn_spike_time, i_cnn_spike_addr, i_cnn_done,
             i_spk_ready, i_clear,
      output o_cnn_spike_ack, o_spk_valid, o_spk_time, o_spk_addr, o_stream_done,
             o_spike_count
   );

   modport master (
      output i_cnn_spike_valid, i_cnn_spike_time, i_cnn_spike_addr, i_cnn_done,
             i_spk_ready, i_clear,
      input  o_cnn_spike_ack, o_spk_valid, o_spk_time, o_spk_addr, o_stream_done,
             o_spike_count
   );

endinterface

// File: rtl/snn_spike_rx_fifo.sv
// Single-clock show-ahead FIFO; head word is forced to zero while empty so outputs are clean after reset.
module spike_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 41
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   // Extra MSB on each pointer distinguishes full from empty when the indices match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

   assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/snn_spike_rx.sv
// SNN-side responder of the four-phase CNN spike handshake: synchronises valid/done,
// acks and buffers each spike once, and streams the buffer to the SNN core.
module snn_spike_rx
   import snn_spike_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic          clk,
   input  logic          rst,
   snn_spike_rx_if.slave bus
);

   logic [SYNC_STAGES-1:0] valid_sync_q;
   logic [SYNC_STAGES-1:0] done_sync_q;
   logic                   valid_s;
   logic                   done_s;

   rx_state_e              state_q, state_d;
   logic                   ack_q, ack_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   stream_done_q;

   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_empty;
   logic                   fifo_full;
   spike_t                 push_spk;
   spike_t                 head_spk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_sync_q <= '0;
         done_sync_q  <= '0;
      end else begin
         valid_sync_q <= {valid_sync_q[SYNC_STAGES-2:0], bus.i_cnn_spike_valid};
         done_sync_q  <= {done_sync_q[SYNC_STAGES-2:0], bus.i_cnn_done};
      end
   end

   assign valid_s = valid_sync_q[SYNC_STAGES-1];
   assign done_s  = done_sync_q[SYNC_STAGES-1];

   // Data buses are only meaningful while valid_s is high; they are never synchronised.
   assign push_spk = {bus.i_cnn_spike_time, bus.i_cnn_spike_addr};

   always_comb begin
      state_d   = state_q;
      ack_d     = ack_q;
      count_d   = count_q;
      fifo_push = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (valid_s && !fifo_full) begin
               fifo_push = 1'b1;
               ack_d     = 1'b1;
               state_d   = RX_WAIT_LOW;
               if (!(&count_q)) count_d = count_q + CNT_W'(1);
            end
         end
         RX_WAIT_LOW: begin
            if (!valid_s) begin
               ack_d   = 1'b0;
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
      if (bus.i_clear) count_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= RX_IDLE;
         ack_q         <= 1'b0;
         count_q       <= '0;
         stream_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ack_q         <= ack_d;
         count_q       <= count_d;
         stream_done_q <= done_s && fifo_empty && (state_q == RX_IDLE) && !valid_s;
      end
   end

   assign fifo_pop = bus.i_spk_ready && !fifo_empty;

   spike_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SPIKE_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .din_i   (push_spk),
      .pop_i   (fifo_pop),
      .dout_o  (head_spk),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign bus.o_cnn_spike_ack = ack_q;
   assign bus.o_spk_valid     = !fifo_empty;
   assign bus.o_spk_time      = head_spk.spk_time;
   assign bus.o_spk_addr      = head_spk.spk_addr;
   assign bus.o_stream_done   = stream_done_q;
   assign bus.o_spike_count   = count_q;

endmodule

// File: tb/tb_snn_spike_rx.sv
// Self-checking bench for snn_spike_rx: acts as the CNN four-phase sender and the SNN consumer,
// predicting delivery order, counts and done gating from a queue-based model.
module tb_snn_spike_rx;
   import snn_spike_pkg::*;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   accepts = 0;          // spikes accepted since last reset/clear
   spike_t exp_q[$];           // spikes sent and not yet delivered, in send order

   snn_spike_rx_if #(.CNT_W(16)) bus ();
   snn_spike_rx_if #(.CNT_W(3))  bus_sat ();

   snn_spike_rx #(.FIFO_DEPTH(16), .SYNC_STAGES(2), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Narrow-counter twin driven by identical stimulus to exercise saturation.
   snn_spike_rx #(.FIFO_DEPTH(16), .SYNC_STAGES(2), .CNT_W(3)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus_sat)
   );

   assign bus_sat.i_cnn_spike_valid = bus.i_cnn_spike_valid;
   assign bus_sat.i_cnn_spike_time  = bus.i_cnn_spike_time;
   assign bus_sat.i_cnn_spike_addr  = bus.i_cnn_spike_addr;
   assign bus_sat.i_cnn_done        = bus.i_cnn_done;
   assign bus_sat.i_spk_ready       = bus.i_spk_ready;
   assign bus_sat.i_clear           = bus.i_clear;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int sat_expect(input int n, input int w);
      int lim;
      lim = (1 << w) - 1;
      return (n > lim) ? lim : n;
   endfunction

   task automatic cnn_raise(input logic [TIME_W-1:0] t, input logic [ADDR_W-1:0] a);
      spike_t s;
      s = spike_t'({t, a});
      bus.i_cnn_spike_time  = t;
      bus.i_cnn_spike_addr  = a;
      bus.i_cnn_spike_valid = 1'b1;
      exp_q.push_back(s);
   endtask

   task automatic cnn_complete();
      int n;
      n = 0;
      while (bus.o_cnn_spike_ack !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.o_cnn_spike_ack !== 1'b1) begin
         errors++;
         $display("FAIL hs_ack_rise got=%b required=1", bus.o_cnn_spike_ack);
      end else begin
         accepts++;
         $display("accept t=%08h a=%03h", bus.i_cnn_spike_time, bus.i_cnn_spike_addr);
      end
      bus.i_cnn_spike_valid = 1'b0;
      n = 0;
      while (bus.o_cnn_spike_ack !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.o_cnn_spike_ack !== 1'b0) begin
         errors++;
         $display("FAIL hs_ack_fall got=%b required=0", bus.o_cnn_spike_ack);
      end
   endtask

   task automatic cnn_handshake();
      @(negedge clk);
      cnn_raise($urandom, 9'($urandom_range(0, 511)));
      cnn_complete();
   endtask

   // Random-ready consumer; compares each popped head against the oldest outstanding spike.
   task automatic drain(input int n, input int budget);
      int got;
      int cyc;
      spike_t s;
      got = 0;
      cyc = 0;
      while (got < n && cyc < budget) begin
         @(negedge clk);
         cyc++;
         bus.i_spk_ready = ($urandom_range(0, 3) != 0);
         if (bus.i_spk_ready && bus.o_spk_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL drain_extra got t=%08h a=%03h required none",
                        bus.o_spk_time, bus.o_spk_addr);
            end else begin
               s = exp_q.pop_front();
               if ({bus.o_spk_time, bus.o_spk_addr} !== s) begin
                  errors++;
                  $display("FAIL drain_order got t=%08h a=%03h required t=%08h a=%03h",
                           bus.o_spk_time, bus.o_spk_addr, s.spk_time, s.spk_addr);
               end else begin
                  $display("pop t=%08h a=%03h", bus.o_spk_time, bus.o_spk_addr);
               end
            end
            got++;
         end
      end
      @(negedge clk);
      bus.i_spk_ready = 1'b0;
      checks++;
      if (got != n) begin
         errors++;
         $display("FAIL drain_count got=%0d required=%0d", got, n);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.o_cnn_spike_ack, bus.o_spk_valid, bus.o_stream_done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got=%b required=000",
                  {bus.o_cnn_spike_ack, bus.o_spk_valid, bus.o_stream_done});
      end
      checks++;
      if (bus.o_spk_time !== '0 || bus.o_spk_addr !== '0) begin
         errors++;
         $display("FAIL reset_data got t=%08h a=%03h required 0", bus.o_spk_time, bus.o_spk_addr);
      end
      checks++;
      if (bus.o_spike_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_count got=%0d required=0", bus.o_spike_count);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (bus.o_spk_valid !== 1'b0 || bus.o_cnn_spike_ack !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle got valid=%b ack=%b required 0 0",
                  bus.o_spk_valid, bus.o_cnn_spike_ack);
      end
   endtask

   task automatic test_single_spike();
      @(negedge clk);
      cnn_raise(32'h0000_0123, 9'h005);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.o_cnn_spike_ack !== 1'b0) begin
         errors++;
         $display("FAIL single_ack_early got=%b required=0", bus.o_cnn_spike_ack);
      end
      @(negedge clk);
      checks++;
      if (bus.o_cnn_spike_ack !== 1'b1) begin
         errors++;
         $display("FAIL single_ack_latency got=%b required=1", bus.o_cnn_spike_ack);
      end
      accepts++;
      checks++;
      if (bus.o_spk_valid !== 1'b1 || bus.o_spk_time !== 32'h123 || bus.o_spk_addr !== 9'h005) begin
         errors++;
         $display("FAIL single_head got v=%b t=%08h a=%03h required 1 00000123 005",
                  bus.o_spk_valid, bus.o_spk_time, bus.o_spk_addr);
      end
      checks++;
      if (bus.o_spike_count !== 16'(accepts)) begin
         errors++;
         $display("FAIL single_count got=%0d required=%0d", bus.o_spike_count, accepts);
      end
      bus.i_cnn_spike_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.o_cnn_spike_ack !== 1'b1) begin
         errors++;
         $display("FAIL single_ack_hold got=%b required=1", bus.o_cnn_spike_ack);
      end
      @(negedge clk);
      checks++;
      if (bus.o_cnn_spike_ack !== 1'b0) begin
         errors++;
         $display("FAIL single_ack_fall got=%b required=0", bus.o_cnn_spike_ack);
      end
      drain(1, 100);
   endtask

   task automatic test_burst();
      int bad;
      @(negedge clk);
      bus.i_clear = 1'b1;
      @(negedge clk);
      bus.i_clear = 1'b0;
      accepts = 0;
      checks++;
      if (bus.o_spike_count !== 16'd0) begin
         errors++;
         $display("FAIL burst_clear got=%0d required=0", bus.o_spike_count);
      end
      bus.i_spk_ready = 1'b0;
      for (int i = 0; i < 16; i++) cnn_handshake();
      @(negedge clk);
      cnn_raise($urandom, 9'($urandom_range(0, 511)));
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.o_cnn_spike_ack !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL burst_backpressure got ack-high cycles=%0d required=0", bad);
      end
      fork
         drain(20, 3000);
         begin
            cnn_complete();
            for (int i = 0; i < 3; i++) cnn_handshake();
         end
      join
      checks++;
      if (bus.o_spike_count !== 16'(accepts) || accepts != 20) begin
         errors++;
         $display("FAIL burst_count got=%0d required=20", bus.o_spike_count);
      end
      checks++;
      if (exp_q.size() != 0 || bus.o_spk_valid !== 1'b0) begin
         errors++;
         $display("FAIL burst_leftover got outstanding=%0d valid=%b required 0 0",
                  exp_q.size(), bus.o_spk_valid);
      end
   endtask

   task automatic test_held_valid();
      int bad;
      int n;
      @(negedge clk);
      cnn_raise($urandom, 9'($urandom_range(0, 511)));
      bad = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (bus.o_cnn_spike_ack !== ((i >= 3) ? 1'b1 : 1'b0)) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL held_ack_profile got bad cycles=%0d required=0", bad);
      end
      accepts++;
      bus.i_cnn_spike_valid = 1'b0;
      n = 0;
      while (bus.o_cnn_spike_ack !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.o_spike_count !== 16'(accepts)) begin
         errors++;
         $display("FAIL held_count got=%0d required=%0d", bus.o_spike_count, accepts);
      end
      drain(1, 100);
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.o_spk_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL held_single_entry got extra-valid cycles=%0d required=0", bad);
      end
   endtask

   task automatic test_done_gating();
      int bad;
      spike_t s;
      for (int i = 0; i < 3; i++) cnn_handshake();
      bus.i_cnn_done = 1'b1;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.o_stream_done !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL done_while_buffered got high cycles=%0d required=0", bad);
      end
      for (int k = 0; k < 3; k++) begin
         s = exp_q.pop_front();
         checks++;
         if ({bus.o_spk_time, bus.o_spk_addr} !== s) begin
            errors++;
            $display("FAIL done_pop_order got t=%08h a=%03h required t=%08h a=%03h",
                     bus.o_spk_time, bus.o_spk_addr, s.spk_time, s.spk_addr);
         end
         bus.i_spk_ready = 1'b1;
         @(negedge clk);
         bus.i_spk_ready = 1'b0;
         checks++;
         if (bus.o_stream_done !== 1'b0 || bus.o_spk_valid !== (k < 2)) begin
            errors++;
            $display("FAIL done_after_pop%0d got done=%b valid=%b required 0 %b",
                     k, bus.o_stream_done, bus.o_spk_valid, (k < 2));
         end
      end
      @(negedge clk);
      checks++;
      if (bus.o_stream_done !== 1'b1) begin
         errors++;
         $display("FAIL done_assert got=%b required=1", bus.o_stream_done);
      end
      bus.i_cnn_done = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.o_stream_done !== 1'b1) begin
         errors++;
         $display("FAIL done_hold got=%b required=1", bus.o_stream_done);
      end
      @(negedge clk);
      checks++;
      if (bus.o_stream_done !== 1'b0) begin
         errors++;
         $display("FAIL done_deassert got=%b required=0", bus.o_stream_done);
      end
   endtask

   task automatic test_clear_vs_increment();
      @(negedge clk);
      cnn_raise($urandom, 9'($urandom_range(0, 511)));
      @(negedge clk);
      @(negedge clk);
      bus.i_clear = 1'b1;
      @(negedge clk);
      bus.i_clear = 1'b0;
      checks++;
      if (bus.o_cnn_spike_ack !== 1'b1) begin
         errors++;
         $display("FAIL clear_accept_ack got=%b required=1", bus.o_cnn_spike_ack);
      end
      accepts = 0;
      checks++;
      if (bus.o_spike_count !== 16'd0) begin
         errors++;
         $display("FAIL clear_wins got=%0d required=0", bus.o_spike_count);
      end
      cnn_complete();
      accepts = 0;
      drain(1, 100);
   endtask

   task automatic test_saturation();
      fork
         drain(10, 3000);
         begin
            for (int i = 0; i < 10; i++) begin
               cnn_handshake();
               if (i == 5) begin
                  checks++;
                  if (bus_sat.o_spike_count !== 3'(sat_expect(accepts, 3))) begin
                     errors++;
                     $display("FAIL sat_below got=%0d required=%0d",
                              bus_sat.o_spike_count, sat_expect(accepts, 3));
                  end
               end
            end
         end
      join
      checks++;
      if (bus_sat.o_spike_count !== 3'(sat_expect(accepts, 3))) begin
         errors++;
         $display("FAIL sat_hold got=%0d required=%0d", bus_sat.o_spike_count, sat_expect(accepts, 3));
      end
      checks++;
      if (bus.o_spike_count !== 16'(sat_expect(accepts, 16))) begin
         errors++;
         $display("FAIL sat_wide_count got=%0d required=%0d", bus.o_spike_count, accepts);
      end
   endtask

   task automatic test_reset_mid_handshake();
      int n;
      for (int i = 0; i < 3; i++) cnn_handshake();
      @(negedge clk);
      cnn_raise($urandom, 9'($urandom_range(0, 511)));
      n = 0;
      while (bus.o_cnn_spike_ack !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.o_cnn_spike_ack !== 1'b1 || bus.o_spk_valid !== 1'b1) begin
         errors++;
         $display("FAIL midrst_setup got ack=%b valid=%b required 1 1",
                  bus.o_cnn_spike_ack, bus.o_spk_valid);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.o_cnn_spike_ack, bus.o_spk_valid, bus.o_stream_done} !== 3'b000 ||
          bus.o_spike_count !== 16'd0) begin
         errors++;
         $display("FAIL midrst_async got ack=%b valid=%b done=%b count=%0d required 0 0 0 0",
                  bus.o_cnn_spike_ack, bus.o_spk_valid, bus.o_stream_done, bus.o_spike_count);
      end
      checks++;
      if (bus.o_spk_time !== '0 || bus.o_spk_addr !== '0) begin
         errors++;
         $display("FAIL midrst_data got t=%08h a=%03h required 0", bus.o_spk_time, bus.o_spk_addr);
      end
      bus.i_cnn_spike_valid = 1'b0;
      exp_q.delete();
      accepts = 0;
      @(negedge clk);
      rst = 1'b0;
      cnn_handshake();
      drain(1, 100);
      checks++;
      if (bus.o_spike_count !== 16'd1) begin
         errors++;
         $display("FAIL midrst_recover got=%0d required=1", bus.o_spike_count);
      end
   endtask

   initial begin
      rst                   = 1'b1;
      bus.i_cnn_spike_valid = 1'b0;
      bus.i_cnn_spike_time  = '0;
      bus.i_cnn_spike_addr  = '0;
      bus.i_cnn_done        = 1'b0;
      bus.i_spk_ready       = 1'b0;
      bus.i_clear           = 1'b0;

      test_reset();
      test_single_spike();
      test_burst();
      test_held_valid();
      test_done_gating();
      test_clear_vs_increment();
      test_saturation();
      test_reset_mid_handshake();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
